// File: rtl/postfix_pkg.sv
// Shared constants and types for the parametrised postfix (RPN) evaluator.
// Operator codes, latched error codes and FSM state encoding live here.
package postfix_pkg;

  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h4;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_OVF  = 2'd1,
    ERR_UNF  = 2'd2,
    ERR_MAL  = 2'd3
  } errCode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // True for the three supported operator nibbles.
  function automatic logic isKnownOp(input logic [3:0] code);
    return (code == OP_ADD) || (code == OP_SUB) || (code == OP_MUL);
  endfunction

endpackage

// File: rtl/postfix_eval_param_if.sv
// Token/result bus between the lab stimulus side (master) and the evaluator (slave).
interface postfix_eval_param_if #(
  parameter int DATA_W = 16,
  parameter int IN_W   = 4
);
  logic              IN_VALID;
  logic              OP_MODE;
  logic [IN_W-1:0]   IN;
  logic              OUT_VALID;
  logic [DATA_W-1:0] OUT;
  logic              ERR;
  logic [1:0]        ERR_CODE;

  modport master (
    output IN_VALID, OP_MODE, IN,
    input  OUT_VALID, OUT, ERR, ERR_CODE
  );

  modport slave (
    input  IN_VALID, OP_MODE, IN,
    output OUT_VALID, OUT, ERR, ERR_CODE
  );
endinterface

// File: rtl/postfix_stack.sv
// DEPTH x DATA_W LIFO with push, replace-top-two and clear operations.
// Clear combined with push yields a stack holding only the pushed value.
module postfix_stack #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 10,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              push,
  input  logic              pop2Push,
  input  logic              clear,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] top,
  output logic [DATA_W-1:0] next,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              lt2
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d, base;
  logic [IDX_W-1:0]  wrIdx;
  logic              wrEn;

  // Callers only request a legal operation; clear applies before the push.
  always_comb begin
    base    = clear ? '0 : count_q;
    count_d = base;
    wrEn    = 1'b0;
    wrIdx   = '0;
    if (push) begin
      wrEn    = 1'b1;
      wrIdx   = IDX_W'(base);
      count_d = base + CNT_W'(1);
    end else if (pop2Push) begin
      wrEn    = 1'b1;
      wrIdx   = IDX_W'(base - CNT_W'(2));
      count_d = base - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Entry contents need no reset: only entries below count_q are ever read.
  always_ff @(posedge CLK) begin
    if (wrEn) begin
      mem_q[wrIdx] <= wrData;
    end
  end

  assign top   = (count_q >= CNT_W'(1)) ? mem_q[IDX_W'(count_q - CNT_W'(1))] : '0;
  assign next  = (count_q >= CNT_W'(2)) ? mem_q[IDX_W'(count_q - CNT_W'(2))] : '0;
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign lt2   = (count_q < CNT_W'(2));

endmodule

// File: rtl/postfix_eval_param.sv
// Parametrised postfix evaluator: FSM, ALU and first-error latch around a LIFO.
// One token per cycle; the result strobes one cycle after the last token.
module postfix_eval_param
  import postfix_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IN_W   = 4,
  parameter int DEPTH  = 10
) (
  input logic                CLK,
  input logic                RESET,
  postfix_eval_param_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  state_t            state_q;
  errCode_t          errLatch_q, tokenErr, finalCode;
  logic              outValid_q, err_q;
  logic [DATA_W-1:0] out_q;
  errCode_t          errCode_q;

  logic              push, pop2Push, clear;
  logic [DATA_W-1:0] wrData, aluRes, stackTop, stackNext;
  logic [CNT_W-1:0]  count;
  logic              full, lt2, evalActive, effFull, effLt2, opLegal;

  postfix_stack #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_stack (
    .CLK     (CLK),
    .RESET   (RESET),
    .push    (push),
    .pop2Push(pop2Push),
    .clear   (clear),
    .wrData  (wrData),
    .top     (stackTop),
    .next    (stackNext),
    .count   (count),
    .full    (full),
    .lt2     (lt2)
  );

  // Outside EVAL the token lands in a stack that is empty or being cleared.
  assign evalActive = (state_q == EVAL);
  assign effFull    = evalActive && full;
  assign effLt2     = !evalActive || lt2;
  assign clear      = (state_q == DONE);
  assign opLegal    = ((bus.IN >> 4) == '0) && isKnownOp(bus.IN[3:0]);

  always_comb begin
    case (bus.IN[3:0])
      OP_ADD:  aluRes = stackNext + stackTop;
      OP_SUB:  aluRes = stackNext - stackTop;
      default: aluRes = stackNext * stackTop;
    endcase
  end

  // Illegal operator codes are reported ahead of underflow.
  always_comb begin
    push     = 1'b0;
    pop2Push = 1'b0;
    wrData   = '0;
    tokenErr = ERR_NONE;
    if (bus.IN_VALID) begin
      if (!bus.OP_MODE) begin
        if (effFull) begin
          tokenErr = ERR_OVF;
        end else begin
          push   = 1'b1;
          wrData = DATA_W'(bus.IN);
        end
      end else if (!opLegal) begin
        tokenErr = ERR_MAL;
      end else if (effLt2) begin
        tokenErr = ERR_UNF;
      end else begin
        pop2Push = 1'b1;
        wrData   = aluRes;
      end
    end
  end

  always_comb begin
    if (errLatch_q != ERR_NONE) begin
      finalCode = errLatch_q;
    end else if (count != CNT_W'(1)) begin
      finalCode = ERR_MAL;
    end else begin
      finalCode = ERR_NONE;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      errLatch_q <= ERR_NONE;
      outValid_q <= 1'b0;
      out_q      <= '0;
      err_q      <= 1'b0;
      errCode_q  <= ERR_NONE;
    end else begin
      outValid_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (bus.IN_VALID) begin
            errLatch_q <= tokenErr;
            state_q    <= EVAL;
          end else begin
            state_q <= IDLE;
          end
        end
        EVAL: begin
          if (bus.IN_VALID) begin
            if (errLatch_q == ERR_NONE) begin
              errLatch_q <= tokenErr;
            end
          end else begin
            state_q    <= DONE;
            outValid_q <= 1'b1;
            out_q      <= stackTop;
            err_q      <= (finalCode != ERR_NONE);
            errCode_q  <= finalCode;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.OUT_VALID = outValid_q;
  assign bus.OUT       = out_q;
  assign bus.ERR       = err_q;
  assign bus.ERR_CODE  = errCode_q;

endmodule
